spi_ram_tester: RTL and testbench
=================================

Name: spi_ram_tester

Overview:
Parametrised SPI-RAM traffic generator and checker, successor to the button-driven read/write demo logic. Drives the spi_ram_controller start/busy command interface. Writes an address-derived pattern over a configurable region, then reads it back and verifies it, counting mismatches and capturing the first failing address. Sits between spi_ram_controller and the board top; last_rdata feeds LedScan.

Parameters:
ADDR_W, 16, RAM address width (byte address)
DATA_W, 32, controller word width
STRIDE, 4, address increment per word (bytes)
NUM_WORDS, 256, words per pass (>=1)
GAP_W, 8, width of the inter-operation idle counter

Ports:
clk12MHz  in  1  clock
rstn  in  1  reset
go  in  1  single-cycle start pulse; in mode 3, also the stop request
mode  in  2  0=write only, 1=verify only, 2=write then verify, 3=continuous write+verify
base_addr  in  ADDR_W  first address; sampled on go
seed  in  DATA_W  pattern seed; sampled on go
gap  in  GAP_W  idle cycles inserted before each command; sampled on go
ram_addr  out  ADDR_W  to controller addr_in
ram_wdata  out  DATA_W  to controller data_in
ram_start_read  out  1  single-cycle read strobe
ram_start_write  out  1  single-cycle write strobe
ram_rdata  in  DATA_W  controller data_out; valid when busy falls
ram_busy  in  1  controller busy
active  out  1  test in progress
done  out  1  single-cycle pulse at test end
pass  out  1  err_count==0 at last completion
err_count  out  16  mismatch count, saturates at 16'hFFFF
first_err_addr  out  ADDR_W  address of first mismatch
last_rdata  out  DATA_W  most recent read word

Behaviour:
- Reset (rstn sync, active-low, clock clk12MHz): all outputs 0 except pass=1; FSM IDLE; mid-operation reset aborts immediately, no further strobes.
- Pattern: word i at addr = base + i*STRIDE (mod 2^ADDR_W, wraps silently); data = seed + zero-extended addr (mod 2^DATA_W).
- States: IDLE -> GAP -> ISSUE -> ACK -> WAIT -> NEXT -> (GAP | PHASE | DONE) -> IDLE.
- IDLE: go latches inputs, clears err_count/first_err_addr, sets active, sets phase (WRITE for modes 0,2,3; VERIFY for 1), index=0.
- GAP: count gap cycles (gap=0 -> zero cycles), then wait for ram_busy=0.
- ISSUE: one cycle; strobe for current phase =1; ram_addr/ram_wdata held stable from ISSUE until leaving WAIT.
- ACK: one cycle; ram_busy ignored (controller raises busy the cycle after start).
- WAIT: stay while ram_busy=1. On busy=0 in VERIFY: last_rdata<=ram_rdata; on mismatch, err_count++ (saturating) and, if first mismatch, first_err_addr<=ram_addr.
- NEXT: index++; index==NUM_WORDS ends phase. WRITE end: mode 0 -> DONE, modes 2,3 -> VERIFY with index=0. VERIFY end: modes 1,2 -> DONE; mode 3 -> seed<=seed+1, WRITE, index=0, unless stop pending -> DONE.
- DONE: done=1 one cycle, pass<=(err_count==0), active<=0.
- go while active: ignored in modes 0-2; in mode 3 sets stop-pending, honoured only at a VERIFY phase end.
- Strobes never both high; never asserted while ram_busy=1.
- Minimum per word: gap + 3 cycles + controller busy time.

Optional Feature:
SPI_RAM_TESTER_ERR_HALT_EN: when defined, the first mismatch goes from WAIT directly to DONE (err_count=1, pass=0), skipping remaining words and loops. When undefined, the full pass always completes and all errors are counted.

Decomposition:
- spi_ram_tester_pkg: state enum, phase enum, MODE_* constants, ERR_SAT=16'hFFFF.
- Sub-module spi_ram_tester_pattern: combinational addr/data generator from base, index, seed (parametrised ADDR_W/DATA_W/STRIDE); shared with the checker compare.

Test Plan:
- Mode 2, NUM_WORDS=4, base=0x0010, seed=0x1000_0000, gap=0, model busy 40 cycles -> writes to 0x10,0x14,0x18,0x1C with data 0x1000_0010..0x1000_001C, 4 reads, done pulse, pass=1, err_count=0.
- Same, model corrupts read at 0x0018 -> err_count=1, first_err_addr=0x0018, pass=0; with ERR_HALT_EN, no read of 0x001C issued.
- Mode 0, base=0xFFF8, NUM_WORDS=4 -> addresses 0xFFF8,0xFFFC,0x0000,0x0004 (wrap); no reads issued.
- gap=5: each strobe preceded by >=5 idle cycles after busy fall; strobe never coincident with busy=1; go during mode 1 ignored.
- Mode 3, seed=0: second write pass uses seed 1 (addr 0 -> data 1); go mid-write -> DONE only after that loop's verify end.
- rstn low during WAIT -> next cycle all outputs reset, active=0, no strobe until new go.

Source files
------------

// File: rtl/spi_ram_tester_pkg.sv
// spi_ram_tester_pkg: shared types and constants for the SPI-RAM traffic
// generator/checker (state and phase enums, mode encodings, error saturation).
package spi_ram_tester_pkg;

  // Main sequencer states; one word operation walks GAP -> ISSUE -> ACK -> WAIT -> NEXT
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_ISSUE,
    ST_ACK,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Which half of the test is running: pattern writes or read-back verification
  typedef enum logic {
    PH_WRITE,
    PH_VERIFY
  } phase_t;

  localparam logic [1:0] MODE_WRITE        = 2'd0;
  localparam logic [1:0] MODE_VERIFY       = 2'd1;
  localparam logic [1:0] MODE_WRITE_VERIFY = 2'd2;
  localparam logic [1:0] MODE_CONTINUOUS   = 2'd3;

  localparam logic [15:0] ERR_SAT = 16'hFFFF;

  // Saturating increment of the mismatch counter
  function automatic logic [15:0] err_inc(input logic [15:0] cnt);
    return (cnt == ERR_SAT) ? cnt : cnt + 16'd1;
  endfunction

  // Verify-only runs start by reading; every other mode starts by writing
  function automatic phase_t start_phase(input logic [1:0] mode);
    return (mode == MODE_VERIFY) ? PH_VERIFY : PH_WRITE;
  endfunction

endpackage

// File: rtl/spi_ram_tester_pattern.sv
// spi_ram_tester_pattern: combinational address/data generator.
// Word i lives at base + i*STRIDE (wrapping in ADDR_W bits) and holds
// seed + zero-extended address (wrapping in DATA_W bits). The same output
// drives the write data and serves as the expected value for read-back.
module spi_ram_tester_pattern
  import spi_ram_tester_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int STRIDE = 4,
  parameter int IDX_W  = 9
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic [ADDR_W-1:0] offset;

  // Address and data for the current word, both wrapping silently
  always_comb begin
    offset = ADDR_W'(index) * ADDR_W'(STRIDE);
    addr   = base + offset;
    data   = seed + DATA_W'(addr);
  end

endmodule

// File: rtl/spi_ram_tester.sv
// spi_ram_tester: SPI-RAM traffic generator and checker driving the
// spi_ram_controller start/busy interface. Writes an address-derived pattern
// over a region, reads it back, counts mismatches and records the first bad
// address. last_rdata is meant for the LED scanner.
// Build option: define SPI_RAM_TESTER_ERR_HALT_EN to stop at the first mismatch.
module spi_ram_tester
  import spi_ram_tester_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int STRIDE    = 4,
  parameter int NUM_WORDS = 256,
  parameter int GAP_W     = 8
) (
  input  logic              clk12MHz,
  input  logic              rstn,
  input  logic              go,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] seed,
  input  logic [GAP_W-1:0]  gap,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_start_read,
  output logic              ram_start_write,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_busy,
  output logic              active,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] last_rdata
);

  // Index must be able to hold NUM_WORDS itself for the end-of-phase compare
  localparam int IDX_W = $clog2(NUM_WORDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS);

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic              stop_q, stop_d;
  logic              active_q, active_d;
  logic              pass_q, pass_d;
  logic [15:0]       err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  logic [DATA_W-1:0] last_rdata_q, last_rdata_d;

  logic [ADDR_W-1:0] pat_addr;
  logic [DATA_W-1:0] pat_data;
  logic [IDX_W-1:0]  idx_inc;
  logic              mismatch;

  spi_ram_tester_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .STRIDE (STRIDE),
    .IDX_W  (IDX_W)
  ) u_pattern (
    .base  (base_q),
    .index (index_q),
    .seed  (seed_q),
    .addr  (pat_addr),
    .data  (pat_data)
  );

  assign idx_inc  = index_q + IDX_W'(1);
  assign mismatch = (ram_rdata != pat_data);

  // Next-state and datapath updates for the word-by-word test sequencer
  always_comb begin
    state_d          = state_q;
    phase_d          = phase_q;
    mode_d           = mode_q;
    base_d           = base_q;
    seed_d           = seed_q;
    gap_d            = gap_q;
    gap_cnt_d        = gap_cnt_q;
    index_d          = index_q;
    stop_d           = stop_q;
    active_d         = active_q;
    pass_d           = pass_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    last_rdata_d     = last_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          mode_d           = mode;
          base_d           = base_addr;
          seed_d           = seed;
          gap_d            = gap;
          err_count_d      = '0;
          first_err_addr_d = '0;
          active_d         = 1'b1;
          stop_d           = 1'b0;
          phase_d          = start_phase(mode);
          index_d          = '0;
          gap_cnt_d        = '0;
          state_d          = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q != gap_q) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end else if (!ram_busy) begin
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        state_d = ST_ACK;
      end

      // The controller only raises busy the cycle after start, so skip one look
      ST_ACK: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (!ram_busy) begin
          state_d = ST_NEXT;
          if (phase_q == PH_VERIFY) begin
            last_rdata_d = ram_rdata;
            if (mismatch) begin
              err_count_d = err_inc(err_count_q);
              if (err_count_q == '0) begin
                first_err_addr_d = pat_addr;
              end
`ifdef SPI_RAM_TESTER_ERR_HALT_EN
              state_d = ST_DONE;
`endif
            end
          end
        end
      end

      ST_NEXT: begin
        gap_cnt_d = '0;
        if (idx_inc != LAST_IDX) begin
          index_d = idx_inc;
          state_d = ST_GAP;
        end else begin
          index_d = '0;
          if (phase_q == PH_WRITE) begin
            if (mode_q == MODE_WRITE) begin
              state_d = ST_DONE;
            end else begin
              phase_d = PH_VERIFY;
              state_d = ST_GAP;
            end
          end else begin
            if ((mode_q == MODE_CONTINUOUS) && !stop_q) begin
              seed_d  = seed_q + DATA_W'(1);
              phase_d = PH_WRITE;
              state_d = ST_GAP;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end

      ST_DONE: begin
        active_d = 1'b0;
        pass_d   = (err_count_q == '0);
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // In continuous mode a second go asks the loop to finish after its verify pass
    if (active_q && go && (mode_q == MODE_CONTINUOUS)) begin
      stop_d = 1'b1;
    end
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk12MHz) begin
    if (!rstn) begin
      state_q          <= ST_IDLE;
      phase_q          <= PH_WRITE;
      mode_q           <= MODE_WRITE;
      base_q           <= '0;
      seed_q           <= '0;
      gap_q            <= '0;
      gap_cnt_q        <= '0;
      index_q          <= '0;
      stop_q           <= 1'b0;
      active_q         <= 1'b0;
      pass_q           <= 1'b1;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      last_rdata_q     <= '0;
    end else begin
      state_q          <= state_d;
      phase_q          <= phase_d;
      mode_q           <= mode_d;
      base_q           <= base_d;
      seed_q           <= seed_d;
      gap_q            <= gap_d;
      gap_cnt_q        <= gap_cnt_d;
      index_q          <= index_d;
      stop_q           <= stop_d;
      active_q         <= active_d;
      pass_q           <= pass_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      last_rdata_q     <= last_rdata_d;
    end
  end

  // Address/data come from registered base/index/seed, so they stay put from ISSUE through WAIT
  assign ram_addr        = pat_addr;
  assign ram_wdata       = pat_data;
  assign ram_start_write = (state_q == ST_ISSUE) && (phase_q == PH_WRITE);
  assign ram_start_read  = (state_q == ST_ISSUE) && (phase_q == PH_VERIFY);
  assign done            = (state_q == ST_DONE);
  assign active          = active_q;
  assign pass            = pass_q;
  assign err_count       = err_count_q;
  assign first_err_addr  = first_err_addr_q;
  assign last_rdata      = last_rdata_q;

endmodule

// File: tb/tb_spi_ram_tester.sv
// tb_spi_ram_tester: table-driven bench for spi_ram_tester with a behavioural
// controller model and an operation scoreboard (NUM_WORDS=4).
module tb_spi_ram_tester;

  localparam int NW = 4;
  localparam logic [31:0] CORRUPT_MASK = 32'h0000_0100;

  logic        clk12MHz = 1'b0;
  logic        rstn = 1'b0;
  logic        go = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] base_addr = 16'h0;
  logic [31:0] seed = 32'h0;
  logic [7:0]  gap = 8'd0;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_start_read;
  logic        ram_start_write;
  logic [31:0] ram_rdata = 32'h0;
  logic        ram_busy = 1'b0;
  logic        active;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [15:0] first_err_addr;
  logic [31:0] last_rdata;

  always #42 clk12MHz = ~clk12MHz;

  spi_ram_tester #(
    .ADDR_W    (16),
    .DATA_W    (32),
    .STRIDE    (4),
    .NUM_WORDS (NW),
    .GAP_W     (8)
  ) dut (
    .clk12MHz        (clk12MHz),
    .rstn            (rstn),
    .go              (go),
    .mode            (mode),
    .base_addr       (base_addr),
    .seed            (seed),
    .gap             (gap),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_start_read  (ram_start_read),
    .ram_start_write (ram_start_write),
    .ram_rdata       (ram_rdata),
    .ram_busy        (ram_busy),
    .active          (active),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_addr  (first_err_addr),
    .last_rdata      (last_rdata)
  );

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
  } op_t;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] base;
    logic [31:0] seed;
    logic [7:0]  gap;
    int          busy_len;
    bit          corrupt;
    logic [15:0] corrupt_addr;
    logic [15:0] exp_err;
    logic [15:0] exp_first;
    bit          exp_pass;
  } vec_t;

  op_t         exp_q[$];
  logic [31:0] mem[int];
  vec_t        vecs[5];

  int          checks = 0;
  int          failures = 0;
  int          busy_len = 8;
  int          busy_cnt = 0;
  int          ops_seen = 0;
  int          idle_cnt = 1000;
  int          cur_gap = 0;
  bit          corrupt_en = 1'b0;
  logic [15:0] corrupt_addr = 16'h0;
  bit          pending_read = 1'b0;
  logic [31:0] pending_rdata = 32'h0;
  logic [31:0] exp_last = 32'h0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp_v);
    end
  endfunction

  function automatic void pushPass(input bit wr, input logic [15:0] b, input logic [31:0] s);
    op_t op;
    for (int i = 0; i < NW; i++) begin
      op.wr   = wr;
      op.addr = b + 16'(i * 4);
      op.data = s + {16'h0, op.addr};
      exp_q.push_back(op);
`ifdef SPI_RAM_TESTER_ERR_HALT_EN
      if (!wr && corrupt_en && (op.addr == corrupt_addr)) return;
`endif
    end
  endfunction

  function automatic void pushOps(input logic [1:0] m, input logic [15:0] b, input logic [31:0] s);
    if (m == 2'd3) begin
      pushPass(1'b1, b, s);
      pushPass(1'b0, b, s);
      pushPass(1'b1, b, s + 32'd1);
      pushPass(1'b0, b, s + 32'd1);
    end else begin
      if (m != 2'd1) pushPass(1'b1, b, s);
      if (m != 2'd0) pushPass(1'b0, b, s);
    end
  endfunction

  // One clock: sample at the falling edge and run the controller model/scoreboard
  task automatic tick();
    op_t op;
    @(negedge clk12MHz);
    if (ram_start_read || ram_start_write) begin
      check("strobe_exclusive", {31'b0, ram_start_read & ram_start_write}, 32'd0);
      check("strobe_vs_busy", {31'b0, ram_busy}, 32'd0);
      check("gap_idle", {31'b0, (idle_cnt >= cur_gap)}, 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_strobe actual_wr=%0b actual_addr=0x%04h required=none", ram_start_write, ram_addr);
      end else begin
        op = exp_q.pop_front();
        check("op_kind", {31'b0, ram_start_write}, {31'b0, op.wr});
        check("op_addr", {16'h0, ram_addr}, {16'h0, op.addr});
        if (op.wr) check("op_wdata", ram_wdata, op.data);
      end
      ops_seen++;
      if (ram_start_write) begin
        mem[int'(ram_addr)] = ram_wdata;
        pending_read = 1'b0;
      end else begin
        pending_rdata = mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : 32'h0;
        if (corrupt_en && (ram_addr == corrupt_addr)) pending_rdata = pending_rdata ^ CORRUPT_MASK;
        pending_read = 1'b1;
      end
      ram_busy  = 1'b1;
      busy_cnt  = busy_len;
      ram_rdata = 32'hDEAD_BEEF;
      idle_cnt  = 0;
    end else if (ram_busy) begin
      busy_cnt--;
      if (busy_cnt <= 0) begin
        ram_busy = 1'b0;
        if (pending_read) begin
          ram_rdata = pending_rdata;
          exp_last  = pending_rdata;
        end
        idle_cnt = 0;
      end
    end else begin
      idle_cnt++;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    cur_gap      = int'(v.gap);
    busy_len     = v.busy_len;
    corrupt_en   = v.corrupt;
    corrupt_addr = v.corrupt_addr;
    pushOps(v.mode, v.base, v.seed);
    mode      = v.mode;
    base_addr = v.base;
    seed      = v.seed;
    gap       = v.gap;
    go        = 1'b1;
    tick();
    go        = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while ((done !== 1'b1) && (n < 5000)) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, {31'b0, done}, 32'd1);
    tick();
    check({name, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  task automatic waitOps(input int target);
    int n = 0;
    while ((ops_seen < target) && (n < 5000)) begin
      tick();
      n++;
    end
    check("ops_reached", {31'b0, (ops_seen >= target)}, 32'd1);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] e_err, input logic [15:0] e_first, input bit e_pass);
    check({name, "_err_count"}, {16'h0, err_count}, {16'h0, e_err});
    check({name, "_first_err_addr"}, {16'h0, first_err_addr}, {16'h0, e_first});
    check({name, "_pass"}, {31'b0, pass}, {31'b0, e_pass});
    check({name, "_last_rdata"}, last_rdata, exp_last);
    check({name, "_active"}, {31'b0, active}, 32'd0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic checkReset(input string name);
    check({name, "_ram_addr"}, {16'h0, ram_addr}, 32'd0);
    check({name, "_ram_wdata"}, ram_wdata, 32'd0);
    check({name, "_strobes"}, {30'b0, ram_start_read, ram_start_write}, 32'd0);
    check({name, "_active"}, {31'b0, active}, 32'd0);
    check({name, "_done"}, {31'b0, done}, 32'd0);
    check({name, "_pass"}, {31'b0, pass}, 32'd1);
    check({name, "_err_count"}, {16'h0, err_count}, 32'd0);
    check({name, "_first_err_addr"}, {16'h0, first_err_addr}, 32'd0);
    check({name, "_last_rdata"}, last_rdata, 32'd0);
  endtask

  initial begin
    vec_t v;
    int   start;

    vecs[0] = '{2'd2, 16'h0010, 32'h1000_0000, 8'd0, 40, 1'b0, 16'h0000, 16'd0, 16'h0000, 1'b1};
    vecs[1] = '{2'd2, 16'h0010, 32'h1000_0000, 8'd0, 12, 1'b1, 16'h0018, 16'd1, 16'h0018, 1'b0};
    vecs[2] = '{2'd0, 16'hFFF8, 32'hA5A5_0000, 8'd0, 6, 1'b0, 16'h0000, 16'd0, 16'h0000, 1'b1};
    vecs[3] = '{2'd1, 16'hFFF8, 32'hA5A5_0000, 8'd5, 6, 1'b0, 16'h0000, 16'd0, 16'h0000, 1'b1};
    vecs[4] = '{2'd2, 16'h0100, 32'hFFFF_FFF0, 8'd2, 5, 1'b0, 16'h0000, 16'd0, 16'h0000, 1'b1};

    rstn = 1'b0;
    repeat (3) tick();
    checkReset("por");
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %0d mode=%0d base=0x%04h", i, vecs[i].mode, vecs[i].base);
      applyStimulus(vecs[i]);
      waitDone($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_first, vecs[i].exp_pass);
    end

    // Verify-only run with gap=5; a second go mid-run must be ignored
    $display("[TB] sequence: go ignored during verify-only");
    v = '{2'd1, 16'h0010, 32'h1000_0000, 8'd5, 10, 1'b0, 16'h0000, 16'd0, 16'h0000, 1'b1};
    start = ops_seen;
    applyStimulus(v);
    waitOps(start + 2);
    mode      = 2'd0;
    base_addr = 16'h0080;
    go        = 1'b1;
    tick();
    go        = 1'b0;
    waitDone("ignore_go");
    checkOutput("ignore_go", 16'd0, 16'h0000, 1'b1);
    check("ignore_go_last", last_rdata, 32'h1000_001C);

    // Continuous mode: stop requested during the second write pass
    $display("[TB] sequence: continuous mode with stop");
    v = '{2'd3, 16'h0000, 32'h0000_0000, 8'd1, 6, 1'b0, 16'h0000, 16'd0, 16'h0000, 1'b1};
    start = ops_seen;
    applyStimulus(v);
    waitOps(start + 9);
    go = 1'b1;
    tick();
    go = 1'b0;
    waitDone("loop");
    checkOutput("loop", 16'd0, 16'h0000, 1'b1);
    check("loop_last", last_rdata, 32'h0000_000D);
    start = ops_seen;
    repeat (100) tick();
    check("loop_no_more_ops", 32'(ops_seen - start), 32'd0);

    // Reset while the first write is waiting on busy
    $display("[TB] sequence: reset during WAIT");
    v = '{2'd2, 16'h0040, 32'h0000_0005, 8'd0, 20, 1'b0, 16'h0000, 16'd0, 16'h0000, 1'b1};
    start = ops_seen;
    applyStimulus(v);
    waitOps(start + 1);
    repeat (5) tick();
    check("pre_reset_active", {31'b0, active}, 32'd1);
    rstn = 1'b0;
    tick();
    checkReset("mid_reset");
    rstn = 1'b1;
    exp_q.delete();
    exp_last = 32'h0;
    start = ops_seen;
    repeat (60) tick();
    check("post_reset_no_ops", 32'(ops_seen - start), 32'd0);
    check("post_reset_active", {31'b0, active}, 32'd0);

    // Fresh run after the abort must work normally
    applyStimulus(v);
    waitDone("recover");
    checkOutput("recover", 16'd0, 16'h0000, 1'b1);
    check("recover_last", last_rdata, 32'h0000_0051);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
